weight_col_sched_vert_16: RTL and testbench

WEIGHT_COL_SCHED_VERT_16 -- requirements
Module: weight_col_sched_vert_16

---
 rtl/weight_col_sched_vert_16_pkg.sv | 17 +
 rtl/weight_col_sched_vert_16_col_encode_8.sv | 52 +++++
 rtl/weight_col_sched_vert_16.sv | 247 ++++++++++++++++++++++++
 tb/tb_weight_col_sched_vert_16.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_col_sched_vert_16_pkg.sv
// Shared constants and FSM state type for the vertical bit-serial MAC weight scheduler.
package weight_col_sched_vert_16_pkg;

  localparam int DATA_WIDTH = 8;   // weight element width = number of column beats
  localparam int VEC_LENGTH = 16;  // weights per vector
  localparam int SEL_WIDTH  = 3;   // per-slot activation select width (0..4)
  localparam int GROUP_SIZE = 8;   // weights per encoder group
  localparam int NUM_SLOTS  = 4;   // MAC slots per group
  localparam int BEAT_COUNT = 9;   // column beats plus one flush beat per vector

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COL   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/weight_col_sched_vert_16_col_encode_8.sv
// Encodes one 8-bit weight column into four MAC slots plus a skip-zero flag.
// The minority value (ones if at most four are set, otherwise zeros) is encoded,
// so at most four indices ever need a slot.
module col_encode_8
  import weight_col_sched_vert_16_pkg::*;
#(
  parameter int SEL_WIDTH = weight_col_sched_vert_16_pkg::SEL_WIDTH
) (
  input  logic [GROUP_SIZE-1:0]          col_i,
  output logic [NUM_SLOTS*SEL_WIDTH-1:0] sel_o,
  output logic [NUM_SLOTS-1:0]           val_o,
  output logic                           skip_o
);

  logic [3:0]                     cnt;
  logic                           skip;
  logic [GROUP_SIZE-1:0]          pick;
  logic [NUM_SLOTS-1:0]           used;
  logic [NUM_SLOTS*SEL_WIDTH-1:0] sel;
  logic                           placed;

  // Popcount, minority selection and greedy lowest-free-slot assignment.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    cnt    = '0;
    used   = '0;
    sel    = '0;
    placed = 1'b0;
    for (int p = 0; p < GROUP_SIZE; p++) begin
      cnt = cnt + 4'(col_i[p]);
    end
    skip = (cnt <= 4'(NUM_SLOTS));
    pick = skip ? col_i : ~col_i;
    for (int p = 0; p < GROUP_SIZE; p++) begin
      if (pick[p]) begin
        placed = 1'b0;
        // Slot j sees local indices j..j+4, so index p may land in slots p-4..p.
        for (int j = 0; j < NUM_SLOTS; j++) begin
          if (!placed && !used[j] && (j >= p - NUM_SLOTS) && (j <= p)) begin
            used[j]                    = 1'b1;
            sel[j*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(p - j);
            placed                     = 1'b1;
          end
        end
      end
    end
    sel_o  = sel;
    val_o  = used;
    skip_o = skip;
  end

endmodule

// File: rtl/weight_col_sched_vert_16.sv
// Weight-side encoder for the vertical bit-serial MAC: turns one accepted weight
// vector into eight column beats (LSB first) followed by one flush beat.
module weight_col_sched_vert_16
  import weight_col_sched_vert_16_pkg::*;
#(
  parameter int DATA_WIDTH = weight_col_sched_vert_16_pkg::DATA_WIDTH,
  parameter int VEC_LENGTH = weight_col_sched_vert_16_pkg::VEC_LENGTH,
  parameter int SEL_WIDTH  = weight_col_sched_vert_16_pkg::SEL_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic                             w_valid_i,
  output logic                             w_ready_o,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] w_data_i,
  input  logic                             cfg_en_mul_i,
  input  logic                             cfg_is_shift_mul_i,
  input  logic [2:0]                       cfg_mul_const_i,
  input  logic                             stall_i,
  output logic [8*SEL_WIDTH-1:0]           act_sel_o,
  output logic [7:0]                       act_val_o,
  output logic [2:0]                       column_idx_o,
  output logic                             is_msb_o,
  output logic [1:0]                       is_skip_zero_o,
  output logic [2:0]                       mul_const_o,
  output logic                             is_shift_mul_o,
  output logic                             en_mul_o,
  output logic                             en_acc_o,
  output logic                             load_accum_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int              NUM_GROUPS = VEC_LENGTH / GROUP_SIZE;
  localparam logic [2:0]      LAST_COL   = 3'(BEAT_COUNT - 2);

  state_e                          state_q, state_d;
  logic [2:0]                      col_q, col_d;
  logic [VEC_LENGTH*DATA_WIDTH-1:0] w_q, w_d;
  logic                            cfg_en_mul_q, cfg_en_mul_d;
  logic                            cfg_shift_q, cfg_shift_d;
  logic [2:0]                      cfg_const_q, cfg_const_d;

  logic [8*SEL_WIDTH-1:0] act_sel_q, act_sel_d;
  logic [7:0]             act_val_q, act_val_d;
  logic [2:0]             col_idx_q, col_idx_d;
  logic                   is_msb_q, is_msb_d;
  logic [1:0]             skip_q, skip_d;
  logic [2:0]             mul_const_q, mul_const_d;
  logic                   shift_q, shift_d;
  logic                   en_mul_q, en_mul_d;
  logic                   en_acc_q, en_acc_d;
  logic                   load_q, load_d;
  logic                   done_q, done_d;

  logic                             accept;
  logic                             load_col, load_flush, go_idle;
  logic [2:0]                       src_col;
  logic [VEC_LENGTH*DATA_WIDTH-1:0] src_w;
  logic [VEC_LENGTH-1:0]            grp_col;
  logic [8*SEL_WIDTH-1:0]           enc_sel;
  logic [7:0]                       enc_val;
  logic [1:0]                       enc_skip;

  assign w_ready_o = (state_q == ST_IDLE) || ((state_q == ST_FLUSH) && !stall_i);
  assign accept    = w_valid_i && w_ready_o;

  // Select the column for the next beat: column 0 of the incoming vector on accept,
  // otherwise the following column of the captured vector.
  always_comb begin
    src_col = accept ? 3'd0 : col_q + 3'd1;
    src_w   = accept ? w_data_i : w_q;
    grp_col = '0;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      grp_col[i] = src_w[i*DATA_WIDTH + int'(src_col)];
    end
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_enc
    col_encode_8 #(.SEL_WIDTH(SEL_WIDTH)) u_enc (
      .col_i  (grp_col[g*GROUP_SIZE +: GROUP_SIZE]),
      .sel_o  (enc_sel[g*NUM_SLOTS*SEL_WIDTH +: NUM_SLOTS*SEL_WIDTH]),
      .val_o  (enc_val[g*NUM_SLOTS +: NUM_SLOTS]),
      .skip_o (enc_skip[g])
    );
  end

  // Next-state logic: capture on handshake, walk the columns, then flush.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    w_d          = w_q;
    cfg_en_mul_d = cfg_en_mul_q;
    cfg_shift_d  = cfg_shift_q;
    cfg_const_d  = cfg_const_q;
    load_col     = 1'b0;
    load_flush   = 1'b0;
    go_idle      = 1'b0;
    if (accept) begin
      state_d      = ST_COL;
      col_d        = 3'd0;
      w_d          = w_data_i;
      cfg_en_mul_d = cfg_en_mul_i;
      cfg_shift_d  = cfg_is_shift_mul_i;
      cfg_const_d  = cfg_mul_const_i;
      load_col     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_COL: begin
          if (!stall_i) begin
            if (col_q == LAST_COL) begin
              state_d    = ST_FLUSH;
              load_flush = 1'b1;
            end else begin
              col_d    = col_q + 3'd1;
              load_col = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (!stall_i) begin
            state_d = ST_IDLE;
            go_idle = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          go_idle = 1'b1;
        end
      endcase
    end
  end

  // Beat assembly: column beat, flush beat, or quiet outputs; otherwise hold.
  always_comb begin
    act_sel_d   = act_sel_q;
    act_val_d   = act_val_q;
    col_idx_d   = col_idx_q;
    is_msb_d    = is_msb_q;
    skip_d      = skip_q;
    mul_const_d = mul_const_q;
    shift_d     = shift_q;
    en_mul_d    = en_mul_q;
    en_acc_d    = en_acc_q;
    load_d      = load_q;
    done_d      = done_q;
    if (load_col) begin
      act_sel_d   = enc_sel;
      act_val_d   = enc_val;
      col_idx_d   = src_col;
      is_msb_d    = (src_col == LAST_COL);
      skip_d      = enc_skip;
      mul_const_d = cfg_const_d;
      shift_d     = cfg_shift_d;
      en_mul_d    = (src_col == 3'd0) && cfg_en_mul_d;
      en_acc_d    = 1'b1;
      load_d      = (src_col == 3'd0);
      done_d      = 1'b0;
    end else if (load_flush) begin
      act_sel_d = '0;
      act_val_d = '0;
      col_idx_d = 3'd0;
      is_msb_d  = 1'b0;
      skip_d    = 2'b11;
      en_mul_d  = 1'b0;
      en_acc_d  = 1'b1;
      load_d    = 1'b0;
      done_d    = 1'b1;
    end else if (go_idle) begin
      act_sel_d   = '0;
      act_val_d   = '0;
      col_idx_d   = 3'd0;
      is_msb_d    = 1'b0;
      skip_d      = 2'b00;
      mul_const_d = 3'd0;
      shift_d     = 1'b0;
      en_mul_d    = 1'b0;
      en_acc_d    = 1'b0;
      load_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  // Sequencing state and the captured vector/config.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state_q      <= ST_IDLE;
      col_q        <= 3'd0;
      w_q          <= '0;
      cfg_en_mul_q <= 1'b0;
      cfg_shift_q  <= 1'b0;
      cfg_const_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      w_q          <= w_d;
      cfg_en_mul_q <= cfg_en_mul_d;
      cfg_shift_q  <= cfg_shift_d;
      cfg_const_q  <= cfg_const_d;
    end
  end

  // Registered beat outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      act_sel_q   <= '0;
      act_val_q   <= '0;
      col_idx_q   <= 3'd0;
      is_msb_q    <= 1'b0;
      skip_q      <= 2'b00;
      mul_const_q <= 3'd0;
      shift_q     <= 1'b0;
      en_mul_q    <= 1'b0;
      en_acc_q    <= 1'b0;
      load_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      act_sel_q   <= act_sel_d;
      act_val_q   <= act_val_d;
      col_idx_q   <= col_idx_d;
      is_msb_q    <= is_msb_d;
      skip_q      <= skip_d;
      mul_const_q <= mul_const_d;
      shift_q     <= shift_d;
      en_mul_q    <= en_mul_d;
      en_acc_q    <= en_acc_d;
      load_q      <= load_d;
      done_q      <= done_d;
    end
  end

  assign act_sel_o      = act_sel_q;
  assign act_val_o      = act_val_q;
  assign column_idx_o   = col_idx_q;
  assign is_msb_o       = is_msb_q;
  assign is_skip_zero_o = skip_q;
  assign mul_const_o    = mul_const_q;
  assign is_shift_mul_o = shift_q;
  assign en_mul_o       = en_mul_q;
  assign load_accum_o   = load_q;
  // A stalled beat is held but must not be consumed downstream.
  assign en_acc_o       = en_acc_q && !stall_i;
  assign done_o         = done_q && !stall_i;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_weight_col_sched_vert_16.sv
// Scoreboard bench: expected beats are pushed when a vector is offered and
// popped/compared on every cycle the DUT shows en_acc.
module tb_weight_col_sched_vert_16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         w_valid = 1'b0;
  logic [127:0] w_data = '0;
  logic         cfg_en_mul = 1'b0;
  logic         cfg_shift = 1'b0;
  logic [2:0]   cfg_const = 3'd0;
  logic         stall = 1'b0;

  logic         w_ready;
  logic [23:0]  act_sel;
  logic [7:0]   act_val;
  logic [2:0]   column_idx;
  logic         is_msb;
  logic [1:0]   is_skip_zero;
  logic [2:0]   mul_const;
  logic         is_shift_mul;
  logic         en_mul, en_acc, load_accum, busy, done;

  always #5 clk = ~clk;

  weight_col_sched_vert_16 dut (
    .clk_i              (clk),
    .reset_ni           (reset_n),
    .w_valid_i          (w_valid),
    .w_ready_o          (w_ready),
    .w_data_i           (w_data),
    .cfg_en_mul_i       (cfg_en_mul),
    .cfg_is_shift_mul_i (cfg_shift),
    .cfg_mul_const_i    (cfg_const),
    .stall_i            (stall),
    .act_sel_o          (act_sel),
    .act_val_o          (act_val),
    .column_idx_o       (column_idx),
    .is_msb_o           (is_msb),
    .is_skip_zero_o     (is_skip_zero),
    .mul_const_o        (mul_const),
    .is_shift_mul_o     (is_shift_mul),
    .en_mul_o           (en_mul),
    .en_acc_o           (en_acc),
    .load_accum_o       (load_accum),
    .busy_o             (busy),
    .done_o             (done)
  );

  typedef struct packed {
    logic [23:0] sel;
    logic [7:0]  val;
    logic [1:0]  skip;
    logic [2:0]  col;
    logic        msb;
    logic        load;
    logic        en_mul;
    logic [2:0]  mc;
    logic        sh;
    logic        done;
  } beat_t;

  beat_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int first_beat = -1;
  int last_beat = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference column encoder written straight from the slot rules.
  function automatic void model_col(input logic [7:0] col, output logic [11:0] sel,
                                    output logic [3:0] val, output logic skip);
    int c, lo, hi;
    logic [7:0] tgt;
    c    = $countones(col);
    skip = (c <= 4);
    tgt  = skip ? col : ~col;
    sel  = '0;
    val  = '0;
    for (int p = 0; p < 8; p++) begin
      if (tgt[p]) begin
        lo = (p > 4) ? p - 4 : 0;
        hi = (p < 3) ? p : 3;
        for (int j = lo; j <= hi; j++) begin
          if (!val[j]) begin
            val[j]          = 1'b1;
            sel[j*3 +: 3]   = 3'(p - j);
            break;
          end
        end
      end
    end
  endfunction

  task automatic push_vec(input logic [127:0] w, input logic em, input logic sh, input logic [2:0] mc);
    beat_t e;
    logic [7:0] col;
    logic [11:0] s;
    logic [3:0] v;
    logic k;
    for (int b = 0; b < 8; b++) begin
      e = '0;
      for (int g = 0; g < 2; g++) begin
        for (int p = 0; p < 8; p++) col[p] = w[(8*g+p)*8 + b];
        model_col(col, s, v, k);
        e.sel[g*12 +: 12] = s;
        e.val[g*4 +: 4]   = v;
        e.skip[g]         = k;
      end
      e.col    = 3'(b);
      e.msb    = (b == 7);
      e.load   = (b == 0);
      e.en_mul = (b == 0) && em;
      e.mc     = mc;
      e.sh     = sh;
      e.done   = 1'b0;
      sb.push_back(e);
    end
    e      = '0;
    e.skip = 2'b11;
    e.mc   = mc;
    e.sh   = sh;
    e.done = 1'b1;
    sb.push_back(e);
  endtask

  task automatic send_vec(input logic [127:0] w, input logic em, input logic sh,
                          input logic [2:0] mc, input bit keep, output logic was_done);
    int n;
    w_valid    = 1'b1;
    w_data     = w;
    cfg_en_mul = em;
    cfg_shift  = sh;
    cfg_const  = mc;
    n = 0;
    while (!w_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("w_ready_wait", w_ready, 1);
    was_done = done;
    push_vec(w, em, sh, mc);
    @(posedge clk); #1;
    if (!keep) w_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [2:0] c);
    int n;
    n = 0;
    while (!(en_acc && column_idx == c) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_col", column_idx, c);
  endtask

  // Output monitor, sampled away from the rising edge.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (reset_n && en_acc) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("act_sel", act_sel, e.sel);
        check("act_val", act_val, e.val);
        check("skip_zero", is_skip_zero, e.skip);
        check("column_idx", column_idx, e.col);
        check("is_msb", is_msb, e.msb);
        check("load_accum", load_accum, e.load);
        check("en_mul", en_mul, e.en_mul);
        check("mul_cfg", {mul_const, is_shift_mul}, {e.mc, e.sh});
        check("done", done, e.done);
        check("busy", busy, 1);
      end
      beat_cnt++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
    end else if (reset_n) begin
      check("done_no_beat", done, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w;
    logic d;

    // Reset state.
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {act_sel, act_val, column_idx, is_msb, is_skip_zero, mul_const,
                       is_shift_mul, en_mul, en_acc, load_accum, busy, done}, 0);
    check("rst_ready", w_ready, 1);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // All zero weights.
    send_vec('0, 1'b0, 1'b0, 3'd0, 0, d);
    drain();

    // All 0xFF weights.
    send_vec({16{8'hFF}}, 1'b0, 1'b0, 3'd0, 0, d);
    drain();

    // Only weight 7 = 1.
    w = '0;
    w[7*8 +: 8] = 8'h01;
    send_vec(w, 1'b0, 1'b0, 3'd0, 0, d);
    drain();

    // Weights 8..12 = 1 (five ones in group 1, column 0).
    w = '0;
    for (int i = 8; i <= 12; i++) w[i*8 +: 8] = 8'h01;
    send_vec(w, 1'b0, 1'b0, 3'd0, 0, d);
    drain();

    // Constant-multiplier config held for the vector, en_mul only on column 0.
    w = {$urandom, $urandom, $urandom, $urandom};
    send_vec(w, 1'b1, 1'b1, 3'd5, 0, d);
    drain();

    // Back-to-back vectors with a two-cycle stall on column 3 of the first.
    beat_cnt   = 0;
    first_beat = -1;
    w = {$urandom, $urandom, $urandom, $urandom};
    send_vec(w, 1'b1, 1'b0, 3'd3, 1, d);
    wait_col(3'd3);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("stall_en_acc", en_acc, 0);
      check("stall_col", column_idx, 3);
      check("stall_sel", act_sel, sb[0].sel);
      check("stall_ready", w_ready, 0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    w = {$urandom & $urandom, $urandom, $urandom | $urandom, $urandom};
    send_vec(w, 1'b0, 1'b1, 3'd2, 0, d);
    check("b2b_flush_at_accept", d, 1);
    check("b2b_col0_next", {en_acc, load_accum}, 2'b11);
    drain();
    check("b2b_beats", beat_cnt, 18);
    check("b2b_span", last_beat - first_beat + 1, 20);

    // A few random vectors with random config.
    for (int k = 0; k < 4; k++) begin
      w = {$urandom, $urandom & $urandom, $urandom, $urandom | $urandom};
      send_vec(w, 1'($urandom), 1'($urandom), 3'($urandom), 0, d);
      drain();
    end

    // Reset mid-vector at column 4.
    w = {$urandom, $urandom, $urandom, $urandom};
    send_vec(w, 1'b1, 1'b1, 3'd6, 0, d);
    wait_col(3'd4);
    reset_n = 1'b0;
    #1;
    check("rst_mid_outs", {act_sel, act_val, column_idx, is_msb, is_skip_zero, mul_const,
                           is_shift_mul, en_mul, en_acc, load_accum, busy, done}, 0);
    check("rst_mid_ready", w_ready, 1);
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_mid_done", done, 0);
    end
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Next vector after reset runs all nine beats from load_accum.
    beat_cnt = 0;
    w = {$urandom, $urandom, $urandom, $urandom};
    send_vec(w, 1'b1, 1'b0, 3'd1, 0, d);
    drain();
    check("post_rst_beats", beat_cnt, 9);

    check("final_busy", busy, 0);
    check("final_ready", w_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
